// File: rtl/bus_arbiter_pkg.sv
// Shared constants and state encoding for the bus arbiter.
// Active-low grant/request levels are named so the polarity reads at the use site.
package bus_arbiter_pkg;

    localparam logic Enable   = 1'b1;
    localparam logic Enable_  = 1'b0;
    localparam logic Disable  = 1'b0;
    localparam logic Disable_ = 1'b1;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StGrant = 2'd1,
        StTurn  = 2'd2
    } arb_state_e;

endpackage

// File: rtl/bus_arbiter_rr_pick.sv
// Combinational round-robin picker: first active request after 'last', wrapping.
// 'req' is active-high here; the caller inverts the active-low bus requests.
module rr_pick
    import bus_arbiter_pkg::*;
#(
    parameter int unsigned NMASTERS = 2,
    localparam int unsigned IdxW = $clog2(NMASTERS)
) (
    input  logic [NMASTERS-1:0] req,
    input  logic [IdxW-1:0]     last,
    output logic [IdxW-1:0]     winner,
    output logic                valid
);

    logic [IdxW-1:0] idx;

    always_comb begin
        winner = '0;
        valid  = Disable;
        idx    = '0;
        for (int i = 1; i <= int'(NMASTERS); i++) begin
            idx = IdxW'((int'(last) + i) % int'(NMASTERS));
            if (!valid && req[idx]) begin
                winner = idx;
                valid  = Enable;
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter with per-grant timeout and a memory-side bus mux.
// One TURN cycle separates every release from the next arbitration.
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int unsigned NMASTERS = 2,
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned TIMEOUT  = 64,
    localparam int unsigned IdxW = $clog2(NMASTERS)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NMASTERS-1:0]       m_breq_,
    input  logic [NMASTERS-1:0]       m_done,
    input  logic [NMASTERS-1:0]       m_memread,
    input  logic [NMASTERS-1:0]       m_memwrite,
    input  logic [NMASTERS*WIDTH-1:0] m_adr,
    input  logic [NMASTERS*WIDTH-1:0] m_wdata,
    output logic [NMASTERS-1:0]       m_bgrt_,
    output logic                      mem_read,
    output logic                      mem_write,
    output logic [WIDTH-1:0]          mem_adr,
    output logic [WIDTH-1:0]          mem_wdata,
    output logic                      busy,
    output logic [IdxW-1:0]           grant_id,
    output logic                      timeout_err,
    output logic [IdxW-1:0]           err_id
);

    localparam int unsigned CntW = $clog2(TIMEOUT + 1);

    arb_state_e      state_q, state_d;
    logic [IdxW-1:0] grant_id_q, grant_id_d;
    logic [IdxW-1:0] last_q, last_d;
    logic [IdxW-1:0] err_id_q, err_id_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            terr_q, terr_d;

    logic [IdxW-1:0] rr_winner;
    logic            rr_valid;

    logic [WIDTH-1:0] adr_arr   [NMASTERS];
    logic [WIDTH-1:0] wdata_arr [NMASTERS];

    for (genvar i = 0; i < NMASTERS; i++) begin : g_unpack
        assign adr_arr[i]   = m_adr[i*WIDTH +: WIDTH];
        assign wdata_arr[i] = m_wdata[i*WIDTH +: WIDTH];
    end

    rr_pick #(
        .NMASTERS (NMASTERS)
    ) u_rr_pick (
        .req    (~m_breq_),
        .last   (last_q),
        .winner (rr_winner),
        .valid  (rr_valid)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            grant_id_q <= '0;
            last_q     <= IdxW'(NMASTERS - 1);
            err_id_q   <= '0;
            cnt_q      <= '0;
            terr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_id_q <= grant_id_d;
            last_q     <= last_d;
            err_id_q   <= err_id_d;
            cnt_q      <= cnt_d;
            terr_q     <= terr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        grant_id_d = grant_id_q;
        last_d     = last_q;
        err_id_d   = err_id_q;
        cnt_d      = cnt_q;
        terr_d     = Disable;
        unique case (state_q)
            StIdle: begin
                if (rr_valid) begin
                    state_d    = StGrant;
                    grant_id_d = rr_winner;
                    last_d     = rr_winner;
                    cnt_d      = '0;
                end
            end
            StGrant: begin
                // done or an abort releases cleanly, even on the timeout cycle
                if (m_done[grant_id_q] || m_breq_[grant_id_q]) begin
                    state_d = StTurn;
                end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
                    state_d  = StTurn;
                    terr_d   = Enable;
                    err_id_d = grant_id_q;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StTurn:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        m_bgrt_   = {NMASTERS{Disable_}};
        busy      = Disable;
        mem_read  = Disable;
        mem_write = Disable;
        mem_adr   = '0;
        mem_wdata = '0;
        if (state_q == StGrant) begin
            m_bgrt_[grant_id_q] = Enable_;
            busy      = Enable;
            mem_read  = m_memread[grant_id_q];
            mem_write = m_memwrite[grant_id_q];
            mem_adr   = adr_arr[grant_id_q];
            mem_wdata = wdata_arr[grant_id_q];
        end
    end

    assign grant_id    = grant_id_q;
    assign err_id      = err_id_q;
    assign timeout_err = terr_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: a cycle model of grant ownership checked every negedge,
// plus directed scenarios with literal expectations.
module tb_bus_arbiter;

    localparam int N  = 2;
    localparam int W  = 32;
    localparam int TO = 64;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [N-1:0]   m_breq_ = '1;
    logic [N-1:0]   m_done = '0;
    logic [N-1:0]   m_memread = '0;
    logic [N-1:0]   m_memwrite = '0;
    logic [N*W-1:0] m_adr = '0;
    logic [N*W-1:0] m_wdata = '0;
    logic [N-1:0]   m_bgrt_;
    logic           mem_read, mem_write, busy, timeout_err;
    logic [W-1:0]   mem_adr, mem_wdata;
    logic [0:0]     grant_id, err_id;

    always #5 clk = ~clk;

    bus_arbiter #(
        .NMASTERS (N),
        .WIDTH    (W),
        .TIMEOUT  (TO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .m_breq_     (m_breq_),
        .m_done      (m_done),
        .m_memread   (m_memread),
        .m_memwrite  (m_memwrite),
        .m_adr       (m_adr),
        .m_wdata     (m_wdata),
        .m_bgrt_     (m_bgrt_),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .mem_adr     (mem_adr),
        .mem_wdata   (mem_wdata),
        .busy        (busy),
        .grant_id    (grant_id),
        .timeout_err (timeout_err),
        .err_id      (err_id)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: who owns the bus, how long it has held it, and the cool-down after release.
    int owner = -1, cool = 0, held = 0, last = N - 1, gid = 0, eid = 0;
    bit err = 0, mvalid = 0;

    initial forever begin
        @(posedge clk);
        if (reset) begin
            owner = -1; cool = 0; held = 0; last = N - 1; gid = 0; eid = 0; err = 0;
            mvalid = 1;
        end else begin
            err = 0;
            if (owner >= 0) begin
                held++;
                if (m_done[owner] || m_breq_[owner]) begin
                    owner = -1; cool = 1;
                end else if (held == TO) begin
                    err = 1; eid = owner; owner = -1; cool = 1;
                end
            end else if (cool > 0) begin
                cool--;
            end else begin
                for (int k = 1; k <= N; k++) begin
                    int c;
                    c = (last + k) % N;
                    if (owner < 0 && !m_breq_[c]) begin
                        owner = c; last = c; gid = c; held = 0;
                    end
                end
            end
        end
    end

    initial forever begin
        logic [N-1:0] eg;
        @(negedge clk);
        if (mvalid) begin
            eg = '1;
            if (owner >= 0) eg[owner] = 1'b0;
            check("model m_bgrt_", 64'(m_bgrt_), 64'(eg));
            check("model busy", 64'(busy), 64'(owner >= 0));
            check("model grant_id", 64'(grant_id), 64'(gid));
            check("model err_id", 64'(err_id), 64'(eid));
            check("model timeout_err", 64'(timeout_err), 64'(err));
            check("model mem_read", 64'(mem_read), (owner >= 0) ? 64'(m_memread[owner]) : 64'd0);
            check("model mem_write", 64'(mem_write),
                  (owner >= 0) ? 64'(m_memwrite[owner]) : 64'd0);
            check("model mem_adr", 64'(mem_adr), (owner >= 0) ? 64'(m_adr[owner*W +: W]) : 64'd0);
            check("model mem_wdata", 64'(mem_wdata),
                  (owner >= 0) ? 64'(m_wdata[owner*W +: W]) : 64'd0);
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        int seq[$];
        int gaps[$];
        int gcnt, idle_run, id, low, errs, eid_seen;
        bit prev_free;

        // Reset state, first grant, bus mux, foreign done ignored
        reset = 1'b1;
        repeat (2) step();
        check("reset m_bgrt_", 64'(m_bgrt_), 64'h3);
        check("reset busy", 64'(busy), 64'h0);
        check("reset grant_id", 64'(grant_id), 64'h0);
        check("reset mem_adr", 64'(mem_adr), 64'h0);
        m_adr      = {32'hBBBB_0001, 32'hAAAA_0000};
        m_wdata    = {32'h2222_2222, 32'h1111_1111};
        m_memread  = 2'b01;
        m_memwrite = 2'b11;
        reset      = 1'b0;
        m_breq_    = 2'b10;
        step();
        check("first m_bgrt_", 64'(m_bgrt_), 64'h2);
        check("first grant_id", 64'(grant_id), 64'h0);
        check("first mem_adr", 64'(mem_adr), 64'hAAAA_0000);
        check("first mem_wdata", 64'(mem_wdata), 64'h1111_1111);
        check("first rd+wr", 64'({mem_read, mem_write}), 64'h3);
        m_done = 2'b10;
        step();
        check("foreign done ignored", 64'(m_bgrt_), 64'h2);
        m_done = 2'b01;
        step();
        check("done release m_bgrt_", 64'(m_bgrt_), 64'h3);
        check("done release mem_write", 64'(mem_write), 64'h0);
        m_done  = 2'b00;
        m_breq_ = 2'b11;
        repeat (3) step();

        // Alternation with done three cycles into each grant
        reset = 1'b1;
        step();
        reset     = 1'b0;
        m_breq_   = 2'b00;
        prev_free = 1;
        idle_run  = 0;
        gcnt      = 0;
        id        = 0;
        for (int cyc = 0; cyc < 60 && seq.size() < 5; cyc++) begin
            step();
            if (m_bgrt_ != 2'b11) begin
                if (prev_free) begin
                    id = (m_bgrt_ == 2'b10) ? 0 : 1;
                    seq.push_back(id);
                    if (seq.size() > 1) gaps.push_back(idle_run);
                    gcnt = 0;
                end
                gcnt++;
                m_done    = (gcnt == 3) ? N'(1 << id) : '0;
                prev_free = 0;
                idle_run  = 0;
            end else begin
                m_done    = '0;
                idle_run++;
                prev_free = 1;
            end
        end
        check("alt grant count", 64'(seq.size()), 64'd5);
        if (seq.size() >= 4) begin
            check("alt grant 0", 64'(seq[0]), 64'd0);
            check("alt grant 1", 64'(seq[1]), 64'd1);
            check("alt grant 2", 64'(seq[2]), 64'd0);
            check("alt grant 3", 64'(seq[3]), 64'd1);
        end
        foreach (gaps[g]) check("alt idle gap", 64'(gaps[g]), 64'd2);
        m_done  = '0;
        m_breq_ = 2'b11;
        repeat (4) step();

        // Timeout on master 1
        reset = 1'b1;
        step();
        reset    = 1'b0;
        m_breq_  = 2'b01;
        low      = 0;
        errs     = 0;
        eid_seen = -1;
        for (int cyc = 0; cyc < 80; cyc++) begin
            step();
            if (m_bgrt_ == 2'b01) low++;
            if (timeout_err) begin
                errs++;
                eid_seen = int'(err_id);
                m_breq_  = 2'b11;
            end
        end
        check("timeout grant cycles", 64'(low), 64'd64);
        check("timeout pulses", 64'(errs), 64'd1);
        check("timeout err_id", 64'(eid_seen), 64'd1);

        // Done on the timeout cycle wins
        m_breq_ = 2'b10;
        low     = 0;
        errs    = 0;
        for (int cyc = 0; cyc < 80; cyc++) begin
            step();
            if (m_bgrt_ == 2'b10) begin
                low++;
                m_done = (low == TO) ? 2'b01 : 2'b00;
            end else begin
                m_done = 2'b00;
                if (low > 0) m_breq_ = 2'b11;
            end
            if (timeout_err) errs++;
        end
        check("done-wins grant cycles", 64'(low), 64'd64);
        check("done-wins no pulse", 64'(errs), 64'd0);
        check("done-wins err_id kept", 64'(err_id), 64'd1);

        // Reset during a grant to master 1
        reset = 1'b1;
        step();
        reset   = 1'b0;
        m_breq_ = 2'b01;
        step();
        check("pre-reset grant", 64'(m_bgrt_), 64'h1);
        step();
        reset = 1'b1;
        step();
        check("reset drops grant", 64'(m_bgrt_), 64'h3);
        check("reset no timeout_err", 64'(timeout_err), 64'h0);
        reset   = 1'b0;
        m_breq_ = 2'b00;
        step();
        check("post-reset winner", 64'(m_bgrt_), 64'h2);
        check("post-reset grant_id", 64'(grant_id), 64'h0);
        m_breq_ = 2'b11;
        repeat (3) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
